// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: registered grant, round-robin tie-break, bounded hold.
// Optional contention counter on stall_cnt is enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int ADDR_W   = 32,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    input  logic [3:0]        wmask0,
    input  logic [3:0]        wmask1,
    output logic              ready0,
    output logic              ready1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam int          HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    logic [1:0]    state, state_nxt;
    logic          last_owner, last_owner_nxt;
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;

    // Handshake: a transfer on port N completes at the rising edge where reqN & readyN.
    // readyN depends only on the registered state, so the requester may hold its
    // fields and sample rdataN anywhere in the cycle.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        hold_cnt_nxt   = hold_cnt;
        case (state)
            IDLE: begin
                hold_cnt_nxt = '0;
                if (req0 && req1)
                    state_nxt = last_owner ? OWN0 : OWN1;
                else if (req0)
                    state_nxt = OWN0;
                else if (req1)
                    state_nxt = OWN1;
            end
            OWN0: begin
                if (req1 && (!req0 || hold_cnt == HOLD_MAX)) begin
                    state_nxt      = OWN1;
                    hold_cnt_nxt   = '0;
                    last_owner_nxt = 1'b0;
                end else if (req0) begin
                    if (hold_cnt != HOLD_MAX)
                        hold_cnt_nxt = hold_cnt + HW'(1);
                end else begin
                    state_nxt      = IDLE;
                    hold_cnt_nxt   = '0;
                    last_owner_nxt = 1'b0;
                end
            end
            OWN1: begin
                if (req0 && (!req1 || hold_cnt == HOLD_MAX)) begin
                    state_nxt      = OWN0;
                    hold_cnt_nxt   = '0;
                    last_owner_nxt = 1'b1;
                end else if (req1) begin
                    if (hold_cnt != HOLD_MAX)
                        hold_cnt_nxt = hold_cnt + HW'(1);
                end else begin
                    state_nxt      = IDLE;
                    hold_cnt_nxt   = '0;
                    last_owner_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            hold_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            hold_cnt   <= hold_cnt_nxt;
        end
    end

    assign ready0    = (state == OWN0);
    assign ready1    = (state == OWN1);
    assign dbg_state = state;

    // Bus fields follow the owner; an async reset forces IDLE so the bus drops at once.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        rdata0    = '0;
        rdata1    = '0;
        if (state == OWN0) begin
            mem_we    = we0 & req0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_wmask = wmask0;
            rdata0    = mem_rdata;
        end else if (state == OWN1) begin
            mem_we    = we1 & req1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_wmask = wmask1;
            rdata1    = mem_rdata;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_q <= '0;
        else if (((req0 && !ready0) || (req1 && !ready1)) && (stall_q != '1))
            stall_q <= stall_q + STAT_W'(1);
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded bench for dmem_arbiter: directed transfers on both ports, a behavioural
// data memory, and a negedge monitor that pops expected completions in order.
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int STAT_W = 16;
    localparam int RW     = 70;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [31:0]       wdata0, wdata1;
    logic [3:0]        wmask0, wmask1;
    logic              ready0, ready1;
    logic [31:0]       rdata0, rdata1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_rdata;
    logic [STAT_W-1:0] stall_cnt;
    logic [1:0]        dbg_state;

    logic [31:0]   mem [0:63];
    logic [RW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    dmem_arbiter #(.MAX_HOLD(4), .ADDR_W(ADDR_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .wmask0(wmask0), .wmask1(wmask1),
        .ready0(ready0), .ready1(ready1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // data memory: combinational read, byte-masked write at the edge
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    function automatic logic [RW-1:0] rec(input logic p, input logic w, input logic [31:0] a,
                                          input logic [31:0] d, input logic [3:0] m);
        return {p, w, a, d, m};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic xfer(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int waited);
        bit done;
        done   = 0;
        waited = 0;
        if (p == 0) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; wmask0 = m;
        end else begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; wmask1 = m;
        end
        while (!done) begin
            @(negedge clk);
            if ((p == 0 ? ready0 : ready1) && !reset) begin
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                waited++;
                if (waited > 60) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_timeout: port %0d addr %h got no ready, required ready", p, a);
                    done = 1;
                end
            end
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) begin
            req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; wmask0 = '0;
        end else begin
            req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; wmask1 = '0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: one expected record per completed transfer
    task automatic monitor();
        logic [RW-1:0] act, exp;
        forever begin
            @(negedge clk);
            if (!reset) begin
                checks++;
                if (ready0 && ready1) begin
                    errors++;
                    $display("FAIL both_ready: got ready0=1 ready1=1 required at most one");
                end
                if ((req0 && ready0) || (req1 && ready1)) begin
                    act = {ready1, mem_we, mem_addr, mem_we ? mem_wdata : (ready1 ? rdata1 : rdata0),
                           mem_wmask};
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_xfer: got %h required no transfer", act);
                    end else begin
                        exp = exp_q.pop_front();
                        if (act !== exp) begin
                            errors++;
                            $display("FAIL xfer: got %h expected %h", act, exp);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int w0, w1, budget;
        reset = 1'b1;
        drop(0);
        drop(1);
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;

        // reset held with both requesting, then port 0 wins the first tie
        exp_q.push_back(rec(0, 1, 32'h20, 32'h1111_1111, 4'hF));
        exp_q.push_back(rec(1, 1, 32'h24, 32'h2222_2222, 4'hF));
        fork
            begin xfer(0, 1'b1, 32'h20, 32'h1111_1111, 4'hF, w0); drop(0); end
            begin xfer(1, 1'b1, 32'h24, 32'h2222_2222, 4'hF, w1); drop(1); end
            begin
                @(negedge clk);
                chk("reset_ready0", ready0, 0);
                chk("reset_ready1", ready1, 0);
                chk("reset_mem_we", mem_we, 0);
                chk("reset_mem_addr", mem_addr, 0);
                chk("reset_stall_cnt", stall_cnt, 0);
                chk("reset_state", dbg_state, 0);
                @(posedge clk);
                #1;
                reset = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("first_grant_ready0", ready0, 1);
                chk("first_grant_ready1", ready1, 0);
            end
        join
        idle(2);

        // single port 0: write then back-to-back read
        exp_q.push_back(rec(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF));
        exp_q.push_back(rec(0, 0, 32'h10, 32'hDEAD_BEEF, 4'h0));
        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, w0);
        chk("idle_latency", w0, 1);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, w0);
        chk("back_to_back", w0, 0);
        drop(0);
        idle(2);

        // hold limit: port 0 owned last, so port 1 opens; blocks of 4 alternate
        for (int i = 0; i < 4; i++) exp_q.push_back(rec(1, 1, 32'h80 + 4*i, 32'hB000_0000 + i, 4'hF));
        for (int i = 0; i < 4; i++) exp_q.push_back(rec(0, 1, 32'h40 + 4*i, 32'hA000_0000 + i, 4'hF));
        for (int i = 4; i < 8; i++) exp_q.push_back(rec(1, 1, 32'h80 + 4*i, 32'hB000_0000 + i, 4'hF));
        for (int i = 4; i < 8; i++) exp_q.push_back(rec(0, 1, 32'h40 + 4*i, 32'hA000_0000 + i, 4'hF));
        fork
            begin
                for (int i = 0; i < 8; i++) xfer(0, 1'b1, 32'h40 + 4*i, 32'hA000_0000 + i, 4'hF, w0);
                drop(0);
            end
            begin
                for (int i = 0; i < 8; i++) xfer(1, 1'b1, 32'h80 + 4*i, 32'hB000_0000 + i, 4'hF, w1);
                drop(1);
            end
        join
`ifdef DMEM_ARB_STATS_EN
        chk("stall_cnt_counts", stall_cnt != 0, 1);
`endif
        idle(2);

        // byte mask from port 1, then a simultaneous request: port 0 wins after port 1
        exp_q.push_back(rec(1, 1, 32'h30, 32'h1122_3344, 4'hF));
        exp_q.push_back(rec(1, 1, 32'h30, 32'h0000_00AB, 4'h1));
        xfer(1, 1'b1, 32'h30, 32'h1122_3344, 4'hF, w1);
        xfer(1, 1'b1, 32'h30, 32'h0000_00AB, 4'h1, w1);
        drop(1);
        idle(2);
        exp_q.push_back(rec(0, 0, 32'h30, 32'h1122_33AB, 4'h0));
        exp_q.push_back(rec(1, 0, 32'h10, 32'hDEAD_BEEF, 4'h0));
        fork
            begin xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, w0); drop(0); end
            begin xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, w1); drop(1); end
        join
        idle(2);

        // reset in the middle of a port 0 write
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h5555_5555; wmask0 = 4'hF;
        @(posedge clk);
        #1;
        chk("pre_reset_mem_we", mem_we, 1);
        reset = 1'b1;
        #1;
        chk("midreset_mem_we", mem_we, 0);
        chk("midreset_ready0", ready0, 0);
        chk("midreset_mem_addr", mem_addr, 0);
        chk("midreset_stall_cnt", stall_cnt, 0);
        @(posedge clk);
        #1;
        drop(0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midreset_mem_kept", mem[4], 32'hDEAD_BEEF);
        idle(2);
        exp_q.push_back(rec(0, 0, 32'h10, 32'hDEAD_BEEF, 4'h0));
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, w0);
        drop(0);

        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        chk("queue_drained", exp_q.size(), 0);
`ifndef DMEM_ARB_STATS_EN
        chk("stall_cnt_tied", stall_cnt, 0);
`endif
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single data memory (mem instance, "data.hex") between the pipelined CPU (port 0) and an auxiliary master (port 1), e.g. a debug loader or DMA.
- Registered grant, round-robin tie-break and a bounded hold limit so that neither port starves.
- Sits between riscvpipeline/aux master and data_mem. The I/O decode in top stays downstream of the CPU address.

Parameters:
MAX_HOLD, 4, max consecutive transfers granted to one port while the other is requesting (≥1)
ADDR_W, 32, address width
STAT_W, 16, width of contention counter (optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req0 / req1  in  1  port request (valid)
we0 / we1  in  1  write enable of request
addr0 / addr1  in  ADDR_W  byte address
wdata0 / wdata1  in  32  write data
wmask0 / wmask1  in  4  byte write mask (sb/sw)
ready0 / ready1  out  1  grant; a transfer completes at the edge where reqN & readyN
rdata0 / rdata1  out  32  read data, valid in the cycle readyN is high
mem_we  out  1  to data_mem memwrite
mem_addr  out  ADDR_W  to data_mem a
mem_wdata  out  32  to data_mem wd
mem_wmask  out  4  to data_mem writemask
mem_rdata  in  32  from data_mem (combinational read)
stall_cnt  out  STAT_W  contention counter (see Optional Feature)

Behaviour:
- States: IDLE, OWN0, OWN1 (registered). Also registered: last_owner (1 bit) and hold_cnt (saturating at MAX_HOLD-1).
- Reset (async, takes effect immediately):
  - state=IDLE, last_owner=1 (port 0 wins the first tie), hold_cnt=0.
  - All outputs 0: ready0/1=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0, rdata0/1=0, stall_cnt=0.
- readyN = (state==OWNN). Combinational from state only, never from req.
- Memory bus mux:
  - In OWNN: mem_addr/wdata/wmask = port N fields, and mem_we = weN & reqN.
  - In IDLE: all mem_* = 0.
  - rdataN = mem_rdata when state==OWNN, else 0.
- Transitions:
  - IDLE:
    - Only req0 → OWN0. Only req1 → OWN1.
    - Both → port != last_owner.
    - None → IDLE.
    - Latency from IDLE is 1 cycle: the first transfer happens in the cycle after req rises.
  - OWNx (other = y):
    - req_y & (!req_x | hold_cnt==MAX_HOLD-1) → OWNy, hold_cnt=0, last_owner=x.
    - Else req_x → stay; hold_cnt increments on each completed transfer, saturating.
    - Else (no requests) → IDLE, last_owner=x, hold_cnt=0.
  - A sole requester holds the grant indefinitely, one transfer per cycle, with no bubble.
  - Switching ports costs no idle cycle: the last transfer of x is followed directly by the first transfer of y.
- Requester rules:
  - A request, once asserted, holds addr/we/wdata/wmask stable until it sees ready.
  - A request may be replaced by the next one in the cycle right after completion (back-to-back).
- Writes land in the memory at the completing edge. A read and a write to the same address in consecutive cycles see ordered results.
- Reset mid-transfer: mem_we drops immediately and no write is committed at the next edge.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined: stall_cnt increments by 1 each cycle in which (req0 & !ready0) | (req1 & !ready1). It saturates at all-ones and clears only on reset.
- Undefined: the stall_cnt port remains and is tied to 0. No counter logic is synthesised.

Test Plan:
- Reset: hold reset, drive req0=req1=1 → ready0=ready1=0, mem_we=0. Release → OWN0 on the next edge (last_owner=1 at reset).
- Single port 0: write addr 0x10 data 0xDEADBEEF mask 0xF at T0, then read 0x10 → ready0 high at T1 and T2. rdata0=0xDEADBEEF at T2. Port 1 is never readied.
- Hold limit: req0 and req1 both continuously high, MAX_HOLD=4 → grants alternate 4 transfers of port 0, then 4 of port 1, repeating. No cycle has both ready0 and ready1.
- Round-robin from IDLE: port 1 completes one transfer, all requests drop, then both request together → port 0 wins.
- Byte mask: port 1 writes 0x000000AB with mask 0x1 onto 0x11223344 → a subsequent read returns 0x112233AB.
- Reset mid-write: assert reset while OWN0 with we0=1 → mem_we=0 immediately and memory is unchanged. With DMEM_ARB_STATS_EN defined, stall_cnt returns to 0.
